// File: rtl/morse_block_translator_if.sv
// Handshake bundle between storage, translator and transmitter.
// master: storage/transmitter side; slave: the translator.
interface morse_block_translator_if #(
  parameter int N = 3
);
  logic [N*10-1:0] sequences;
  logic            storage_sent;
  logic            tx_ack;
  logic [N*8-1:0]  translated_characters;
  logic [N-1:0]    invalid_mask;
  logic            transmit;
  logic            busy;
  logic            overrun;

  modport master (
    output sequences,
    output storage_sent,
    output tx_ack,
    input  translated_characters,
    input  invalid_mask,
    input  transmit,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sequences,
    input  storage_sent,
    input  tx_ack,
    output translated_characters,
    output invalid_mask,
    output transmit,
    output busy,
    output overrun
  );
endinterface

// File: rtl/morse_block_translator.sv
// Block Morse translator: captures NUM_CHARS 10-bit sequences,
// decodes one slot per clock to ASCII, then raises transmit.
// Ports: clk, rst (sync, active high), bus (slave modport):
//   sequences/storage_sent/tx_ack in;
//   translated_characters/invalid_mask/transmit/busy/overrun out.
module morse_block_translator #(
  parameter int         NUM_CHARS = 3,
  parameter bit         ACK_MODE  = 1'b1,
  parameter logic [7:0] ERR_CHAR  = 8'h3F
) (
  input logic                     clk,
  input logic                     rst,
  morse_block_translator_if.slave bus
);

  localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_CHARS*10-1:0] seq_q, seq_d;
  logic [NUM_CHARS*8-1:0] chars_q, chars_d;
  logic [NUM_CHARS-1:0]   mask_q, mask_d;
  logic                   tx_q, tx_d;
  logic                   ovr_q, ovr_d;
  logic [9:0]             slot;
  logic [8:0]             dec;

  // Returns {error, ascii}. Only exact, pad-terminated ITU
  // patterns match, so illegal symbols and data-after-pad
  // fall through to the error default.
  function automatic logic [8:0] decode(input logic [9:0] s);
    logic [8:0] r;
    r = {1'b1, ERR_CHAR};
    case (s)
      10'b11_11_11_11_11: r = {1'b0, 8'h00};
      10'b00_01_11_11_11: r = {1'b0, 8'h41};
      10'b01_00_00_00_11: r = {1'b0, 8'h42};
      10'b01_00_01_00_11: r = {1'b0, 8'h43};
      10'b01_00_00_11_11: r = {1'b0, 8'h44};
      10'b00_11_11_11_11: r = {1'b0, 8'h45};
      10'b00_00_01_00_11: r = {1'b0, 8'h46};
      10'b01_01_00_11_11: r = {1'b0, 8'h47};
      10'b00_00_00_00_11: r = {1'b0, 8'h48};
      10'b00_00_11_11_11: r = {1'b0, 8'h49};
      10'b00_01_01_01_11: r = {1'b0, 8'h4A};
      10'b01_00_01_11_11: r = {1'b0, 8'h4B};
      10'b00_01_00_00_11: r = {1'b0, 8'h4C};
      10'b01_01_11_11_11: r = {1'b0, 8'h4D};
      10'b01_00_11_11_11: r = {1'b0, 8'h4E};
      10'b01_01_01_11_11: r = {1'b0, 8'h4F};
      10'b00_01_01_00_11: r = {1'b0, 8'h50};
      10'b01_01_00_01_11: r = {1'b0, 8'h51};
      10'b00_01_00_11_11: r = {1'b0, 8'h52};
      10'b00_00_00_11_11: r = {1'b0, 8'h53};
      10'b01_11_11_11_11: r = {1'b0, 8'h54};
      10'b00_00_01_11_11: r = {1'b0, 8'h55};
      10'b00_00_00_01_11: r = {1'b0, 8'h56};
      10'b00_01_01_11_11: r = {1'b0, 8'h57};
      10'b01_00_00_01_11: r = {1'b0, 8'h58};
      10'b01_00_01_01_11: r = {1'b0, 8'h59};
      10'b01_01_00_00_11: r = {1'b0, 8'h5A};
      10'b01_01_01_01_01: r = {1'b0, 8'h30};
      10'b00_01_01_01_01: r = {1'b0, 8'h31};
      10'b00_00_01_01_01: r = {1'b0, 8'h32};
      10'b00_00_00_01_01: r = {1'b0, 8'h33};
      10'b00_00_00_00_01: r = {1'b0, 8'h34};
      10'b00_00_00_00_00: r = {1'b0, 8'h35};
      10'b01_00_00_00_00: r = {1'b0, 8'h36};
      10'b01_01_00_00_00: r = {1'b0, 8'h37};
      10'b01_01_01_00_00: r = {1'b0, 8'h38};
      10'b01_01_01_01_00: r = {1'b0, 8'h39};
      default:            r = {1'b1, ERR_CHAR};
    endcase
    return r;
  endfunction

  always_comb begin
    slot = '1;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx_q == IW'(i)) begin
        slot = seq_q[(NUM_CHARS-1-i)*10 +: 10];
      end
    end
  end

  assign dec = decode(slot);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    chars_d = chars_q;
    mask_d  = mask_q;
    tx_d    = tx_q;
    ovr_d   = ovr_q;
    if (bus.storage_sent && state_q != IDLE) begin
      ovr_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.storage_sent) begin
          seq_d   = bus.sequences;
          chars_d = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          if (idx_q == IW'(i)) begin
            chars_d[(NUM_CHARS-1-i)*8 +: 8] = dec[7:0];
            mask_d[NUM_CHARS-1-i] = dec[8];
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!ACK_MODE || bus.tx_ack) begin
          tx_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      chars_q <= '0;
      mask_q  <= '0;
      tx_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      chars_q <= chars_d;
      mask_q  <= mask_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.translated_characters = chars_q;
  assign bus.invalid_mask          = mask_q;
  assign bus.transmit              = tx_q;
  assign bus.busy                  = (state_q != IDLE);
  assign bus.overrun               = ovr_q;

endmodule
